edge_gen: RTL and testbench

Programmable pulse-train generator. It drives a single-bit line with P pulses, each with a programmed high time and low time, and so produces the rising and falling edges that our synchronizing edge detectors consume downstream. It is the transmit-side counterpart of edge detection and is used as a stimulus and strobe source on the same clock domain. Software-style control is a start/busy/done handshake with abort.

---
 rtl/edge_gen.sv | 143 ++++++++++++++
 tb/tb_edge_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_gen.sv
// Programmable pulse-train generator: P pulses of H active and L inactive cycles,
// with registered rise/fall markers and a start/busy/done/abort handshake.
module edge_gen #(
  parameter int CNT_W  = 16,
  parameter int NUM_W  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] low_cnt,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic             rise,
  output logic             fall,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted in a cycle where busy=0 and abort=0; busy rises
  // the next cycle. done pulses one cycle after the last inactive phase, with
  // busy already low. abort while busy forces idle outputs on the next cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACT   = 2'd1,
    INACT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [NUM_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] high_clamp;
  logic [CNT_W-1:0] low_clamp;

  always_comb begin
    high_clamp = (high_cnt == '0) ? CNT_ONE : high_cnt;
    low_clamp  = (low_cnt == '0) ? CNT_ONE : low_cnt;

    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    high_d  = high_q;
    low_d   = low_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          high_d  = high_clamp;
          low_d   = low_clamp;
          pulse_d = num_pulses;
          if (num_pulses == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ACT;
            phase_d = high_clamp;
          end
        end
      end
      ACT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_q == CNT_ONE) begin
          state_d = INACT;
          phase_d = low_q;
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      INACT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_q == CNT_ONE) begin
          if (pulse_q == NUM_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ACT;
            pulse_d = pulse_q - NUM_ONE;
            phase_d = high_q;
          end
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    busy_d = (state_d != IDLE);
    data_d = (state_d == ACT) ^ INVERT;
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pulse_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      data_q  <= INVERT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      high_q  <= high_d;
      low_q   <= low_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_edge_gen.sv
// Bench for edge_gen: a normal and an inverted instance share stimulus and are
// checked every cycle against a train-timing reference model.
module tb_edge_gen;

  localparam int CW = 4;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] high_cnt = '0;
  logic [CW-1:0] low_cnt = '0;
  logic [NW-1:0] num_pulses = '0;

  logic       data_a, busy_a, done_a, rise_a, fall_a;
  logic       data_b, busy_b, done_b, rise_b, fall_b;
  logic [1:0] state_a, state_b;

  edge_gen #(.CNT_W(CW), .NUM_W(NW), .INVERT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .high_cnt(high_cnt), .low_cnt(low_cnt), .num_pulses(num_pulses),
    .data_out(data_a), .busy(busy_a), .done(done_a), .rise(rise_a), .fall(fall_a),
    .state_dbg(state_a)
  );

  edge_gen #(.CNT_W(CW), .NUM_W(NW), .INVERT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .high_cnt(high_cnt), .low_cnt(low_cnt), .num_pulses(num_pulses),
    .data_out(data_b), .busy(busy_b), .done(done_b), .rise(rise_b), .fall(fall_b),
    .state_dbg(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one record for the most recent accepted train.
  bit tr_valid = 1'b0;
  int tr_n, tr_h, tr_l, tr_p, tr_m;
  bit tr_ab;
  bit prev_exp = 1'b0;

  function automatic bit m_busy(input int c);
    int len;
    if (!tr_valid) return 1'b0;
    len = tr_p * (tr_h + tr_l);
    if (c < tr_n + 1 || c > tr_n + len) return 1'b0;
    if (tr_ab && c > tr_m) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_data(input int c);
    if (!m_busy(c)) return 1'b0;
    return ((c - tr_n - 1) % (tr_h + tr_l)) < tr_h;
  endfunction

  function automatic bit m_done(input int c);
    if (!tr_valid || tr_ab) return 1'b0;
    return c == tr_n + tr_p * (tr_h + tr_l) + 1;
  endfunction

  // Model update on the edge that closes cycle cyc.
  always @(posedge clk) begin
    if (!rst) begin
      if (!m_busy(cyc)) begin
        if (start && !abort) begin
          tr_valid = 1'b1;
          tr_n  = cyc;
          tr_h  = (high_cnt == 0) ? 1 : int'(high_cnt);
          tr_l  = (low_cnt == 0) ? 1 : int'(low_cnt);
          tr_p  = int'(num_pulses);
          tr_ab = 1'b0;
        end
      end else if (abort) begin
        tr_ab = 1'b1;
        tr_m  = cyc;
      end
    end
    cyc++;
  end

  // Scoreboard: compare both instances every cycle on the falling edge.
  always @(negedge clk) begin
    bit ed, er, ef, eb, edn;
    if (rst) begin
      tr_valid = 1'b0;
      prev_exp = 1'b0;
    end
    ed  = m_data(cyc);
    eb  = m_busy(cyc);
    edn = m_done(cyc);
    er  = ed & ~prev_exp;
    ef  = ~ed & prev_exp;
    prev_exp = ed;
    check_bit("a_data", data_a, ed);
    check_bit("a_busy", busy_a, eb);
    check_bit("a_done", done_a, edn);
    check_bit("a_rise", rise_a, er);
    check_bit("a_fall", fall_a, ef);
    check_bit("b_data", data_b, ~ed);
    check_bit("b_busy", busy_b, eb);
    check_bit("b_done", done_b, edn);
    check_bit("b_rise", rise_b, ef);
    check_bit("b_fall", fall_b, er);
  end

  // driver tasks
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start(input int h, input int l, input int p);
    @(negedge clk);
    high_cnt   = CW'(h);
    low_cnt    = CW'(l);
    num_pulses = NW'(p);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("rst_a_data", data_a, 1'b0);
    check_bit("rst_a_busy", busy_a, 1'b0);
    check_bit("rst_a_done", done_a, 1'b0);
    check_bit("rst_b_data", data_b, 1'b1);
    check_bit("rst_b_busy", busy_b, 1'b0);
    check_bit("rst_b_done", done_b, 1'b0);
    idle_cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(2);

    pulse_start(2, 3, 2);
    idle_cycles(14);

    pulse_start(0, 0, 3);
    idle_cycles(10);

    pulse_start(3, 3, 0);
    idle_cycles(4);

    // start mid-train is ignored
    pulse_start(4, 4, 1);
    @(negedge clk);
    high_cnt = CW'(1); low_cnt = CW'(1); num_pulses = NW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(12);

    // abort in the active phase, then restart immediately
    pulse_start(5, 2, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    high_cnt = CW'(2); low_cnt = CW'(2); num_pulses = NW'(2);
    @(negedge clk);
    start = 1'b0;
    idle_cycles(12);

    // abort together with start while idle drops the start
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    idle_cycles(3);

    pulse_start(1, 1, 1);
    idle_cycles(4);

    pulse_start(3, 3, 2);
    idle_cycles(2);
    async_reset_check();
    pulse_start(1, 2, 1);
    idle_cycles(6);

    // maximum counts
    pulse_start(15, 15, 7);
    idle_cycles(215);

    // randomized traffic, including parameter changes while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      high_cnt   = ($urandom_range(0, 19) == 0) ? CW'(15) : CW'($urandom_range(0, 4));
      low_cnt    = ($urandom_range(0, 19) == 0) ? CW'(15) : CW'($urandom_range(0, 4));
      num_pulses = ($urandom_range(0, 19) == 0) ? NW'(7) : NW'($urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    idle_cycles(220);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
